spi_load_sequencer: RTL
=======================

// Module: spi_load_sequencer
// PURPOSE
//  Controller between the SPI byte receiver and the weight/input RAM plus neural-net core.
//  Turns the receiver's (data, address) stream into single-cycle RAM writes and counts the bytes.
//  When the link goes idle it checks the byte total, starts the net and waits for it to finish.
//  It then pulses a comm reset so the receiver is re-armed for the next frame.
// PARAMETERS
//  EXPECTED_BYTES  25'd4992     exact byte count for a valid frame
//  ADDR_IDLE       25'h1ffffff  receiver address value meaning "no byte yet"
//  NET_TIMEOUT     32'd50000000 max CLOCK_50 cycles in RUN (1 s) before error
// PORTS
//  CLOCK_50        in   1   system clock
//  RST_N           in   1   reset, synchronous, active-low
//  rx_data         in   8   last received byte from receiver
//  rx_address      in   25  receiver byte address (ADDR_IDLE after receiver reset)
//  rx_disable_now  in   1   receiver flag: SPI enable high for the disable time (link idle)
//  comm_reset_req  out  1   1-cycle pulse; drives the receiver's comm-reset input (active-high here)
//  mem_we          out  1   RAM write strobe
//  mem_addr        out  25  RAM write address
//  mem_wdata       out  8   RAM write data
//  net_start       out  1   1-cycle start pulse to the net core
//  net_busy        in   1   net core busy
//  byte_count      out  25  bytes written in the current frame
//  load_error      out  1   sticky; set on bad count or timeout, cleared on the next frame's first byte
//  state_dbg       out  3   current state encoding (for LEDs)
// BEHAVIOUR
//  Reset (RST_N=0 at a clock edge):
//   - all outputs 0; state IDLE; prev_addr <= ADDR_IDLE.
//  States:
//   - IDLE  -> LOAD   on a new byte.
//   - LOAD  -> CHECK  when rx_disable_now=1 and byte_count!=0.
//   - CHECK -> START  if byte_count==EXPECTED_BYTES; else -> REARM with load_error<=1.
//   - START -> RUN    after net_start has been high for exactly 1 cycle.
//   - RUN   -> REARM  when net_busy falls. Checked only after net_busy has been seen high.
//   - RUN   -> REARM  if NET_TIMEOUT cycles elapse first; load_error<=1.
//   - REARM: comm_reset_req=1 for 1 cycle -> IDLE. prev_addr <= ADDR_IDLE; byte_count kept until the next frame.
//  New-byte detect:
//   - condition: rx_address!=prev_addr && rx_address!=ADDR_IDLE; prev_addr registered every cycle.
//   - in IDLE the first new byte clears byte_count and load_error.
//  Write latency:
//   - the cycle after detection: mem_we=1 for exactly 1 cycle, mem_addr=rx_address, mem_wdata=rx_data.
//   - data and address are sampled in the detect cycle; byte_count increments in the same cycle as mem_we.
//  Boundaries:
//   - the receiver saturates at its max address, so no further detects occur; a count mismatch then shows in CHECK.
//   - byte_count saturates at 25'h1ffffff.
//   - new-byte detects outside IDLE/LOAD are ignored; no write. A frame sent while the net runs is dropped and re-armed.
//   - rx_disable_now=1 in IDLE: stay in IDLE.
//   - rx_disable_now=1 and a detect in the same cycle in LOAD: the byte is written, then -> CHECK; the count includes it.
//   - RST_N low mid-LOAD or mid-RUN: immediate return to IDLE, no comm_reset_req pulse; net_start stays 0.
//  Widths:
//   - counters are unsigned; the timeout counter is 32 bit and is cleared on entering RUN.
// STRUCTURE
//  Shared package spi_load_pkg:
//   - state localparams IDLE=0, LOAD=1, CHECK=2, START=3, RUN=4, REARM=5 (3 bit).
//   - ADDR_IDLE; EXPECTED_BYTES default.
//  One sub-module, byte_strobe_gen: prev_addr register plus detect and the 1-cycle delayed write strobe.
//  The FSM, counters and timeout stay in the top level.
// TESTING
//  1. Reset -> all outputs 0, state_dbg=0.
//     Addresses 0..4991 with data=addr[7:0], then rx_disable_now=1:
//     - 4992 mem_we pulses, each 1 cycle after its address change, with matching address and data.
//     - byte_count=4992; net_start pulses once.
//  2. Send 4990 bytes then go idle:
//     - load_error=1; no net_start; comm_reset_req pulses once; state returns to 0.
//  3. Valid frame, net_busy high 100 cycles then low:
//     - REARM is entered 1 cycle after the fall; comm_reset_req=1 for exactly 1 cycle.
//  4. Hold net_busy high with NET_TIMEOUT=1000:
//     - load_error=1 after 1000 cycles in RUN; then REARM.
//  5. Address changes while in RUN -> mem_we stays 0.
//     Then a valid second frame -> load_error cleared on its first byte; byte_count restarts at 1.
//  6. Pull RST_N low for 1 cycle mid-LOAD at byte 2000:
//     - state=IDLE next cycle; all outputs 0; comm_reset_req never pulses.

Source files
------------

// File: rtl/spi_load_pkg.sv
// Shared widths, default parameters and state encoding for the SPI load sequencer.
package spi_load_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_IDLE_DEF      = 25'h1ffffff;
    localparam logic [ADDR_W-1:0] EXPECTED_BYTES_DEF = 25'd4992;
    localparam logic [31:0]       NET_TIMEOUT_DEF    = 32'd50000000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        START = 3'd3,
        RUN   = 3'd4,
        REARM = 3'd5
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/spi_load_sequencer_byte_strobe_gen.sv
// Detects each new receiver byte and turns it into a registered one-cycle RAM write.
module byte_strobe_gen
    import spi_load_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_IDLE = ADDR_IDLE_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic [ADDR_W-1:0] rx_address_i,
    input  logic              enable_i,
    input  logic              rearm_i,
    output logic              accept_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o
);

    logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              detect;

    assign detect      = (rx_address_i != prev_addr_q) && (rx_address_i != ADDR_IDLE);
    assign accept_o    = detect && enable_i;
    // Forgetting the last address on re-arm lets the next frame start at any address.
    assign prev_addr_d = rearm_i ? ADDR_IDLE : rx_address_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            prev_addr_q <= ADDR_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register here samples the pre-edge values.
            prev_addr_q <= prev_addr_d;
            we_q        <= accept_o;
            if (accept_o) begin
                addr_q <= rx_address_i;
                data_q <= rx_data_i;
            end
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = data_q;

endmodule

// File: rtl/spi_load_sequencer.sv
// Loads one SPI frame into RAM, checks its length, runs the net core and re-arms the receiver.
module spi_load_sequencer
    import spi_load_pkg::*;
#(
    parameter logic [ADDR_W-1:0] EXPECTED_BYTES = EXPECTED_BYTES_DEF,
    parameter logic [ADDR_W-1:0] ADDR_IDLE      = ADDR_IDLE_DEF,
    parameter logic [31:0]       NET_TIMEOUT    = NET_TIMEOUT_DEF
) (
    input  logic              CLOCK_50,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] rx_data,
    input  logic [ADDR_W-1:0] rx_address,
    input  logic              rx_disable_now,
    output logic              comm_reset_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              net_start,
    input  logic              net_busy,
    output logic [ADDR_W-1:0] byte_count,
    output logic              load_error,
    output logic [2:0]        state_dbg
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              load_error_q, load_error_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              busy_seen_q, busy_seen_d;
    logic              accept;
    logic              count_bad;
    logic              busy_done;
    logic              timed_out;

    byte_strobe_gen #(
        .ADDR_IDLE (ADDR_IDLE)
    ) u_strobe (
        .clk_i        (CLOCK_50),
        .rst_n_i      (RST_N),
        .rx_data_i    (rx_data),
        .rx_address_i (rx_address),
        .enable_i     ((state_q == IDLE) || (state_q == LOAD)),
        .rearm_i      (state_q == REARM),
        .accept_o     (accept),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata)
    );

    assign count_bad = (state_q == CHECK) && (count_q != EXPECTED_BYTES);
    // A falling edge only counts once the core has actually reported busy.
    assign busy_done = (state_q == RUN) && busy_seen_q && !net_busy;
    assign timed_out = (state_q == RUN) && !busy_done && (tmo_q == NET_TIMEOUT - 32'd1);

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    if (rx_disable_now && (count_q != '0)) state_d = CHECK;
            CHECK:   state_d = count_bad ? REARM : START;
            START:   state_d = RUN;
            RUN:     if (busy_done || timed_out) state_d = REARM;
            REARM:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        net_start      = 1'b0;
        comm_reset_req = 1'b0;
        case (state_q)
            START:   net_start      = 1'b1;
            REARM:   comm_reset_req = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        count_d      = count_q;
        load_error_d = load_error_q;
        tmo_d        = tmo_q;
        busy_seen_d  = busy_seen_q;

        if (accept) begin
            count_d = (state_q == IDLE) ? ADDR_W'(1) : sat_inc(count_q);
        end

        if (accept && (state_q == IDLE)) begin
            load_error_d = 1'b0;
        end else if (count_bad || timed_out) begin
            load_error_d = 1'b1;
        end

        case (state_q)
            START: begin
                tmo_d       = '0;
                busy_seen_d = 1'b0;
            end
            RUN: begin
                tmo_d       = tmo_q + 32'd1;
                busy_seen_d = busy_seen_q | net_busy;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            count_q      <= '0;
            load_error_q <= 1'b0;
            tmo_q        <= '0;
            busy_seen_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            load_error_q <= load_error_d;
            tmo_q        <= tmo_d;
            busy_seen_q  <= busy_seen_d;
        end
    end

    assign byte_count = count_q;
    assign load_error = load_error_q;
    assign state_dbg  = state_q;

endmodule
